// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU among NREQ requesters.
// Optional opcode legality check enabled by defining ALU_SHARE_ARB_OPCHECK_EN.
module alu_share_arb #(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [6*NREQ-1:0]    req_code,
  input  logic [32*NREQ-1:0]   req_rv1,
  input  logic [32*NREQ-1:0]   req_rv2,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic [5:0]           alu_code,
  output logic [31:0]          alu_rv1,
  output logic [31:0]          alu_rv2,
  input  logic [31:0]          alu_rvout
);

  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;
  localparam int unsigned CW = 6;
  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e          state_q;
  logic [IW-1:0]   last_q;
  logic [IW-1:0]   owner_q;
  logic [CW-1:0]   code_q;
  logic [DW-1:0]   rv1_q;
  logic [DW-1:0]   rv2_q;
  logic [DW-1:0]   resp_data_q;
  logic [NREQ-1:0] resp_valid_q;

  logic            hi_vld_c;
  logic            lo_vld_c;
  logic [IW-1:0]   hi_idx_c;
  logic [IW-1:0]   lo_idx_c;
  logic            gnt_vld_c;
  logic [IW-1:0]   gnt_idx_c;
  logic [CW-1:0]   sel_code_c;
  logic [DW-1:0]   sel_rv1_c;
  logic [DW-1:0]   sel_rv2_c;
  logic [NREQ-1:0] owner_oh_c;
  logic            resp_done_c;
  logic [DW-1:0]   capt_data_c;

  // Rotating priority: lowest valid index above last wins, else lowest valid index overall.
  always_comb begin
    hi_vld_c = 1'b0;
    lo_vld_c = 1'b0;
    hi_idx_c = '0;
    lo_idx_c = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_vld_c = 1'b1;
        lo_idx_c = IW'(i);
        if (IW'(i) > last_q) begin
          hi_vld_c = 1'b1;
          hi_idx_c = IW'(i);
        end
      end
    end
    gnt_vld_c = lo_vld_c;
    gnt_idx_c = hi_vld_c ? hi_idx_c : lo_idx_c;
  end

  always_comb begin
    sel_code_c = '0;
    sel_rv1_c  = '0;
    sel_rv2_c  = '0;
    req_ready  = '0;
    owner_oh_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx_c == IW'(i)) begin
        sel_code_c = req_code[CW*i +: CW];
        sel_rv1_c  = req_rv1[DW*i +: DW];
        sel_rv2_c  = req_rv2[DW*i +: DW];
      end
      req_ready[i]  = reset_n && (state_q == IDLE) && gnt_vld_c && (gnt_idx_c == IW'(i));
      owner_oh_c[i] = (owner_q == IW'(i));
    end
  end

  assign resp_done_c = |(resp_valid_q & resp_ready);

`ifdef ALU_SHARE_ARB_OPCHECK_EN
  logic op_legal_c;
  logic resp_err_q;

  always_comb begin
    op_legal_c = 1'b0;
    case (code_q[4:0])
      5'b01000, 5'b11000, 5'b01001, 5'b01010, 5'b01011,
      5'b01100, 5'b01101, 5'b11101, 5'b01110, 5'b01111: op_legal_c = 1'b1;
      default: op_legal_c = 1'b0;
    endcase
  end

  // Illegal opcodes return zero instead of whatever the ALU happens to produce.
  assign capt_data_c = op_legal_c ? alu_rvout : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_err_q <= 1'b0;
    end else if (state_q == EXEC) begin
      resp_err_q <= !op_legal_c;
    end
  end

  assign resp_err = resp_err_q;
`else
  assign capt_data_c = alu_rvout;
  assign resp_err    = 1'b0;
`endif

  // Sequencer: accept one op, capture the ALU result, hold it until the owner takes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= IW'(NREQ - 1);
      owner_q      <= '0;
      code_q       <= '0;
      rv1_q        <= '0;
      rv2_q        <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld_c) begin
            code_q  <= sel_code_c;
            rv1_q   <= sel_rv1_c;
            rv2_q   <= sel_rv2_c;
            owner_q <= gnt_idx_c;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          resp_data_q  <= capt_data_c;
          resp_valid_q <= owner_oh_c;
          state_q      <= RESP;
        end
        RESP: begin
          if (resp_done_c) begin
            resp_valid_q <= '0;
            last_q       <= owner_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign alu_code   = code_q;
  assign alu_rv1    = rv1_q;
  assign alu_rv2    = rv2_q;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Round-robin arbiter and sequencer that shares the single combinational 32-bit ALU between up to four requesters (e.g. integer datapath, address generator, branch-compare unit). It accepts one operation at a time through a valid/ready handshake and registers the opcode and operands feeding the ALU. It then captures the ALU result into a register and returns it to the owning requester through a valid/ready response handshake. The block sits between the requester units and the ALU instance; the ALU itself stays purely combinational.

## Interface
- NREQ, 2: number of requesters; legal range is 2 to 4.
- clk  in  1  the single clock. All state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  bit i high: requester i presents an operation.
- req_ready  out  NREQ  bit i high: the arbiter accepts requester i this cycle.
- req_code  in  6*NREQ  ALU opcode of requester i in bits [6i+5:6i].
- req_rv1  in  32*NREQ  first operand of requester i in bits [32i+31:32i].
- req_rv2  in  32*NREQ  second operand of requester i in bits [32i+31:32i].
- resp_valid  out  NREQ  bit i high: resp_data holds requester i's result.
- resp_ready  in  NREQ  bit i high: requester i takes the result.
- resp_data  out  32  registered ALU result.
- resp_err  out  1  illegal opcode flag, qualified by resp_valid; see Configuration.
- alu_code  out  6  opcode driven to the ALU.
- alu_rv1  out  32  first operand driven to the ALU.
- alu_rv2  out  32  second operand driven to the ALU.
- alu_rvout  in  32  ALU result.

## Operation
- States: IDLE, EXEC, RESP. Encoding is free.
- IDLE:
  - The grant is the first requester with req_valid set, searched from index last+1 upward, modulo NREQ.
  - req_ready is asserted only for the granted index. It is combinational from req_valid and last.
  - On handshake (req_valid[g] & req_ready[g]), latch code, rv1 and rv2 into the operand registers and g into owner. Go to EXEC.
- EXEC:
  - The ALU is driven from the operand registers.
  - At the edge, capture alu_rvout into resp_data and capture resp_err. Go to RESP.
- RESP:
  - Only resp_valid[owner] is high.
  - When resp_ready[owner] is high, set last = owner and go to IDLE.
  - resp_ready bits of non-owners are ignored.
- req_ready is all zero in EXEC and RESP. A requester that holds req_valid simply waits.
- alu_code, alu_rv1 and alu_rv2 always reflect the operand registers and are stable outside the latch edge.
- The block does no arithmetic. Operands and opcode pass through unmodified, full 32-bit width.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE; last = NREQ-1, so requester 0 has first priority.
  - owner, the operand registers, resp_data and resp_err all go to 0.
  - req_ready and resp_valid go low.
  - Any in-flight operation is discarded with no response.
- Latency:
  - Request accepted at edge E0.
  - Result registered at E0+1; resp_valid is high from E0+1.
  - Earliest next accept is the edge after the response handshake, one cycle spent in IDLE.
  - Minimum period is 3 cycles per operation.
- If resp_ready is already high when resp_valid rises, the response completes at E0+2.
- Simultaneous requests: exactly one is granted per IDLE cycle. Fairness is strict rotation: a requester waits at most NREQ-1 operations.
- A requester dropping req_valid in IDLE before the handshake is legal. Arbitration is re-evaluated each cycle.
- resp_data and resp_err are held constant throughout RESP.

## Configuration
- Macro: ALU_SHARE_ARB_OPCHECK_EN.
- Defined:
  - In EXEC, the opcode's code[4:0] is checked against the legal set: 01000, 11000, 01001, 01010, 01011, 01100, 01101, 11101, 01110, 01111.
  - Any other value sets resp_err=1 and forces resp_data to 0, instead of capturing the undefined ALU output.
- Not defined:
  - resp_err is tied to 0.
  - resp_data always captures alu_rvout.
  - No checking logic is generated.

## Test plan
- Single op, NREQ=2, requester 0: code 001000, rv1=5, rv2=7, resp_ready held high.
  - req_ready[0] is high at E0; resp_valid[0] is high at E0+1 with resp_data=12; back in IDLE at E0+2.
- Contention: both requesters valid continuously, 4 operations each, out of reset.
  - Grants alternate 0,1,0,1.
  - Each response goes to the correct resp_valid bit; SUB 10-3 returns 7.
- Backpressure: requester 1 issues SRA 0x80000000 by 4; resp_ready[1] is held low for 5 cycles.
  - resp_data stays 0xF8000000.
  - req_ready stays 0 for all requesters the whole time.
  - Completion occurs on the cycle resp_ready rises.
- Reset mid-op: assert reset_n low during EXEC.
  - All outputs are at reset values immediately.
  - After release, a fresh request from requester 1 is granted ahead of a simultaneous one from requester 0 only if requester 0 is not valid; otherwise requester 0 wins.
- Opcode check: code 000111 with rv1=1, rv2=1.
  - With ALU_SHARE_ARB_OPCHECK_EN defined: resp_err=1, resp_data=0.
  - Without it: resp_err=0 and resp_data equals alu_rvout.
- NREQ=4 rotation: requesters 1 and 3 valid, last=1.
  - Grant is 3, then 1, then 3.
